regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file; successor of the single-write, two-read core register file.
- Adds N read and M write ports with same-cycle bypass.
- Adds a busy-bit scoreboard for the issue/hazard logic and a req/ack debug port that cannot collide with core writes.
- Sits between id (reads, scoreboard set) and ex/wb (writes); the debug port connects to the jtag module.

---
 rtl/regfile_mp.sv | 138 +++++++++++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD bypassed read ports, NWR write ports, a busy-bit
// scoreboard for hazard detection, and a req/ack debug port that yields to core writes.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int STARVE   = 8,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                sb_set_i,
    input  logic [AW-1:0]       sb_addr_i,
    input  logic                dbg_req_i,
    input  logic                dbg_we_i,
    input  logic [AW-1:0]       dbg_addr_i,
    input  logic [XLEN-1:0]     dbg_wdata_i,
    output logic                dbg_ack_o,
    output logic [XLEN-1:0]     dbg_rdata_o,
    output logic                dbg_hold_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    // Wide enough to hold STARVE itself; the blocked counter saturates there.
    localparam int CW = $clog2(STARVE + 2);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];

    logic [1:0]      dbg_state;
    logic [CW-1:0]   blk_cnt;
    logic [XLEN-1:0] dbg_rdata;
    logic            dbg_wr_grant;
    logic            dbg_rd_grant;
    logic            dbg_blocked;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wa[i] = wr_addr_i[i*AW +: AW];
            wd[i] = wr_data_i[i*XLEN +: XLEN];
        end
    end

    // Returns {hit, data}: hit = some enabled write port targets this address this cycle.
    function automatic logic [XLEN:0] read_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        logic            hit;
        d   = regs[a];
        hit = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en_i[i] && wa[i] == a) begin
                d   = wd[i];
                hit = 1'b1;
            end
        end
        if (is_zero(a)) d = '0;
        return {hit, d};
    endfunction

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic [XLEN:0] r;
        assign a                           = rd_addr_i[k*AW +: AW];
        assign r                           = read_port(a);
        assign rd_data_o[k*XLEN +: XLEN]   = r[XLEN-1:0];
        assign rd_busy_o[k]                = busy[a] & ~r[XLEN];
    end

    assign dbg_rd_grant = (dbg_state == S_WAIT) && !dbg_we_i;
    assign dbg_wr_grant = (dbg_state == S_WAIT) && dbg_we_i && (wr_en_i == '0);
    assign dbg_blocked  = (dbg_state == S_WAIT) && dbg_we_i && (wr_en_i != '0);

    assign dbg_ack_o   = (dbg_state == S_ACK);
    assign dbg_rdata_o = dbg_rdata;
    assign dbg_hold_o  = (blk_cnt == CW'(STARVE));

    // Clears first, set last so a same-cycle issue of the same destination wins.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en_i[i]) busy_nxt[wa[i]] = 1'b0;
        end
        if (dbg_wr_grant) busy_nxt[dbg_addr_i] = 1'b0;
        if (sb_set_i) busy_nxt[sb_addr_i] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            busy      <= '0;
            dbg_state <= S_IDLE;
            blk_cnt   <= '0;
            dbg_rdata <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en_i[i] && !is_zero(wa[i])) regs[wa[i]] <= wd[i];
            end
            if (dbg_wr_grant && !is_zero(dbg_addr_i)) regs[dbg_addr_i] <= dbg_wdata_i;
            busy <= busy_nxt;

            if (dbg_blocked) begin
                if (blk_cnt != CW'(STARVE)) blk_cnt <= blk_cnt + CW'(1);
            end else begin
                blk_cnt <= '0;
            end

            // Debug reads see the stored value only; a core write in the same cycle is not bypassed.
            if (dbg_rd_grant) dbg_rdata <= is_zero(dbg_addr_i) ? '0 : regs[dbg_addr_i];

            case (dbg_state)
                S_IDLE:  if (dbg_req_i) dbg_state <= S_WAIT;
                S_WAIT:  if (dbg_rd_grant || dbg_wr_grant) dbg_state <= S_ACK;
                S_ACK:   dbg_state <= S_IDLE;
                default: dbg_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: write conflicts, bypass, scoreboard, debug port, reset abort.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_hold;

    int n_vec = 0;
    int n_err = 0;

    regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .sb_set_i    (sb_set),
        .sb_addr_i   (sb_addr),
        .dbg_req_i   (dbg_req),
        .dbg_we_i    (dbg_we),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_ack_o   (dbg_ack),
        .dbg_rdata_o (dbg_rdata),
        .dbg_hold_o  (dbg_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        wr_en  = '0;
        sb_set = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*5 +: 5]   = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rdd(input int p);
        return rd_data[p*32 +: 32];
    endfunction

    initial begin
        rst = 1'b1;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        rd(0, 5); rd(1, 3);
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #2;
        chk("reset_rd0", rdd(0), 32'h0);
        chk("reset_busy", {30'd0, rd_busy}, 32'h0);
        chk("reset_ack", {31'd0, dbg_ack}, 32'h0);
        chk("reset_hold", {31'd0, dbg_hold}, 32'h0);
        chk("reset_rdata", dbg_rdata, 32'h0);
        chk("reset_state", {30'd0, dut.dbg_state}, 32'h0);

        // Same-address write conflict: port 1 wins, both bypassed and stored.
        step(); core_idle(); wr(0, 5, 32'hAAAA0000); wr(1, 5, 32'h5555FFFF); rd(0, 5); #2;
        chk("conflict_bypass", rdd(0), 32'h5555FFFF);
        step(); core_idle(); #2;
        chk("conflict_stored", rdd(0), 32'h5555FFFF);

        step(); core_idle(); wr(0, 3, 32'h12345678); rd(1, 3); #2;
        chk("bypass_x3", rdd(1), 32'h12345678);
        step(); core_idle(); wr(1, 0, 32'hFFFFFFFF); rd(0, 0); #2;
        chk("x0_bypass", rdd(0), 32'h0);
        step(); core_idle(); #2;
        chk("x0_stored", rdd(0), 32'h0);
        chk("x3_stored", rdd(1), 32'h12345678);

        // Scoreboard.
        step(); core_idle(); sb_set = 1'b1; sb_addr = 5'd7; rd(0, 7); #2;
        chk("sb_before_edge", {31'd0, rd_busy[0]}, 32'h0);
        step(); core_idle(); #2;
        step(); core_idle(); #2;
        chk("sb_busy", {31'd0, rd_busy[0]}, 32'h1);
        step(); core_idle(); wr(0, 7, 32'h77); #2;
        chk("sb_clear_bypass", {31'd0, rd_busy[0]}, 32'h0);
        chk("x7_bypass", rdd(0), 32'h77);
        step(); core_idle(); #2;
        chk("sb_clear_stored", {31'd0, rd_busy[0]}, 32'h0);
        step(); core_idle(); sb_set = 1'b1; sb_addr = 5'd7; wr(1, 7, 32'h88); #2;
        step(); core_idle(); #2;
        chk("sb_set_wins", {31'd0, rd_busy[0]}, 32'h1);
        chk("x7_stored", rdd(0), 32'h88);

        // Debug read of x9 with a concurrent core write in the grant cycle.
        step(); core_idle(); wr(0, 9, 32'hDEADBEEF); #2;
        step(); core_idle(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9; #2;
        chk("dr_ack_c0", {31'd0, dbg_ack}, 32'h0);
        step(); core_idle(); wr(0, 9, 32'h1); #2;
        chk("dr_ack_c1", {31'd0, dbg_ack}, 32'h0);
        step(); core_idle(); rd(0, 9); #2;
        chk("dr_ack_c2", {31'd0, dbg_ack}, 32'h1);
        chk("dr_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("x9_core_write", rdd(0), 32'h1);
        dbg_req = 1'b0;
        step(); #2;
        chk("dr_ack_drop", {31'd0, dbg_ack}, 32'h0);
        chk("dr_rdata_held", dbg_rdata, 32'hDEADBEEF);

        // Debug write of x4 starved by core writes until hold asserts.
        step(); core_idle(); sb_set = 1'b1; sb_addr = 5'd4; #2;
        step(); core_idle(); wr(0, 10, 32'h10);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'hCAFE; #2;
        for (int i = 0; i < 8; i++) begin
            step(); core_idle(); wr(0, 10, 32'h20 + i); #2;
            chk("dw_hold_low", {31'd0, dbg_hold}, 32'h0);
            chk("dw_ack_low", {31'd0, dbg_ack}, 32'h0);
        end
        step(); core_idle(); #2;
        chk("dw_hold_high", {31'd0, dbg_hold}, 32'h1);
        chk("dw_ack_hold", {31'd0, dbg_ack}, 32'h0);
        step(); core_idle(); rd(0, 4); #2;
        chk("dw_ack", {31'd0, dbg_ack}, 32'h1);
        chk("dw_hold_clear", {31'd0, dbg_hold}, 32'h0);
        chk("dw_x4", rdd(0), 32'h0000CAFE);
        chk("dw_x4_busy", {31'd0, rd_busy[0]}, 32'h0);
        dbg_req = 1'b0;
        step(); #2;
        chk("dw_ack_drop", {31'd0, dbg_ack}, 32'h0);

        // Reset while a blocked debug write waits.
        step(); core_idle(); wr(0, 10, 32'h1);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'hBAD; rd(0, 9); rd(1, 7); #2;
        step(); core_idle(); wr(0, 10, 32'h2); rst = 1'b1; #2;
        chk("rst_in_wait", {30'd0, dut.dbg_state}, 32'h1);
        step(); rst = 1'b0; core_idle(); dbg_req = 1'b0; #2;
        chk("rst_ack", {31'd0, dbg_ack}, 32'h0);
        chk("rst_state", {30'd0, dut.dbg_state}, 32'h0);
        chk("rst_x9", rdd(0), 32'h0);
        chk("rst_x7", rdd(1), 32'h0);
        chk("rst_x7_busy", {31'd0, rd_busy[1]}, 32'h0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        chk("rst_hold", {31'd0, dbg_hold}, 32'h0);
        step(); core_idle(); rd(0, 4); #2;
        chk("rst_no_ack", {31'd0, dbg_ack}, 32'h0);
        chk("rst_x4", rdd(0), 32'h0);

        // Fresh debug write then read after reset.
        step(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'h1234; #2;
        step(); #2;
        chk("fresh_wr_ack_c1", {31'd0, dbg_ack}, 32'h0);
        step(); rd(0, 12); #2;
        chk("fresh_wr_ack", {31'd0, dbg_ack}, 32'h1);
        chk("fresh_x12", rdd(0), 32'h1234);
        dbg_req = 1'b0;
        step(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd12; #2;
        step(); #2;
        step(); #2;
        chk("fresh_rd_ack", {31'd0, dbg_ack}, 32'h1);
        chk("fresh_rd_data", dbg_rdata, 32'h1234);
        dbg_req = 1'b0;
        step(); #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
